gate_tt_checker: RTL and testbench
==================================

GATE_TT_CHECKER -- requirements
Module: gate_tt_checker

Interface
REQ-001 Parameter EXPECTED, default 4'b1110, expected f per vector; bit i is f for vector i (OR truth table).
REQ-002 Parameter SETTLE, default 2, DUT settle cycles per vector; legal range 1..15.
REQ-003 clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request one full truth-table sweep.
REQ-006 a  output  1  DUT stimulus, equal to vec_idx[1] during a sweep.
REQ-007 b  output  1  DUT stimulus, equal to vec_idx[0] during a sweep.
REQ-008 f  input  1  DUT response under test.
REQ-009 vec_idx  output  2  index of the vector currently applied.
REQ-010 busy  output  1  high while a sweep is in progress.
REQ-011 done  output  1  high while the result of a completed sweep is held.
REQ-012 pass  output  1  high in DONE when fail_mask is zero.
REQ-013 fail_mask  output  4  bit i is set when vector i produced a mismatch.

Function
REQ-014 The FSM SHALL have the states IDLE, APPLY, WAIT, SAMPLE and DONE; all outputs SHALL be registered.
REQ-015 IDLE: start=1 SHALL go to APPLY and set vec_idx=0 and fail_mask=0; start=0 SHALL stay in IDLE.
REQ-016 APPLY SHALL last 1 cycle with a/b driven from vec_idx, load the settle count with SETTLE, then go to WAIT.
REQ-017 WAIT SHALL last exactly SETTLE cycles with a/b held stable, then go to SAMPLE.
REQ-018 SAMPLE SHALL last 1 cycle and set fail_mask[vec_idx] when f != EXPECTED[vec_idx]; a clear bit SHALL never be set otherwise.
REQ-019 SAMPLE with vec_idx<3 SHALL increment vec_idx and go to APPLY.
REQ-020 SAMPLE with vec_idx=3 SHALL go to DONE; vec_idx SHALL NOT wrap to 0.
REQ-021 Each vector SHALL take SETTLE+2 cycles.
REQ-022 done SHALL rise exactly 4*(SETTLE+2) rising edges after the edge that samples start in IDLE (16 edges at SETTLE=2).
REQ-023 busy SHALL be 1 in APPLY, WAIT and SAMPLE, and 0 in IDLE and DONE.
REQ-024 start while busy SHALL be ignored and SHALL NOT alter vec_idx, fail_mask or timing.
REQ-025 DONE SHALL hold done=1 and pass=(fail_mask==0), keep fail_mask frozen, and drive a=b=0.
REQ-026 start=1 in DONE SHALL clear done, pass and fail_mask and begin a new sweep, as from IDLE.
REQ-027 pass SHALL be 0 whenever done=0.
REQ-028 a=b=0 SHALL hold in IDLE.
REQ-029 f SHALL be compared only in SAMPLE; f is treated as synchronous to clk and no synchronizer is included.

Reset
REQ-030 rst=1 at a rising edge SHALL force IDLE with a=b=0, vec_idx=0, busy=0, done=0, pass=0 and fail_mask=0.
REQ-031 rst SHALL take priority over start and over any in-progress state, including mid-sweep; no partial result SHALL be retained.
REQ-032 start sampled together with rst SHALL be discarded.

Structure
REQ-033 Package gate_tt_pkg SHALL hold the state typedef (IDLE, APPLY, WAIT, SAMPLE, DONE), NUM_VECTORS=4 and the settle-count width constant.
REQ-034 The settle countdown SHALL be a sub-module settle_timer with ports clk, rst, load, load_val and expired; all other logic stays in gate_tt_checker.

Verification
REQ-035 The bench SHALL cover: behavioural OR DUT with defaults, pulse start -> done at edge 16, pass=1, fail_mask=4'b0000, a/b sequence 00,01,10,11.
REQ-036 The bench SHALL cover: AND DUT with EXPECTED=4'b1110 -> pass=0, fail_mask=4'b0110.
REQ-037 The bench SHALL cover: f stuck at 1 with EXPECTED=4'b1110 -> fail_mask=4'b0001; f stuck at 0 -> fail_mask=4'b1110.
REQ-038 The bench SHALL cover: SETTLE=1, start -> done at edge 12; start held high during the sweep -> identical timing and result.
REQ-039 The bench SHALL cover: rst asserted in WAIT of vector 2 -> next cycle IDLE with all outputs 0; a new start gives a full clean sweep.
REQ-040 The bench SHALL cover: start in DONE after a failing sweep, with an OR DUT -> done drops next cycle, fail_mask clears, and the new sweep ends with pass=1.

Source files
------------

// File: rtl/gate_tt_pkg.sv
// Shared types and constants for the two-input gate truth-table checker.
package gate_tt_pkg;
  localparam int NUM_VECTORS = 4;
  localparam int SETTLE_W    = 4;

  typedef enum logic [2:0] {IDLE, APPLY, WAIT, SAMPLE, DONE} state_t;
endpackage

// File: rtl/settle_timer.sv
// Settle-cycle countdown. It loads on the last APPLY cycle.
// expired is high on the final WAIT cycle.
module settle_timer
  import gate_tt_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [SETTLE_W-1:0] load_val,
  output logic                expired
);
  logic [SETTLE_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                cnt <= '0;
    else if (load)          cnt <= load_val;
    else if (cnt != '0)     cnt <= cnt - 1'b1;
  end

  assign expired = (cnt == SETTLE_W'(1));
endmodule

// File: rtl/gate_tt_checker.sv
// Sweeps all four (a,b) vectors into a 2-input gate and compares f against EXPECTED.
// Every output is a flop updated together with the state register.
module gate_tt_checker
  import gate_tt_pkg::*;
#(
  parameter logic [3:0] EXPECTED = 4'b1110,
  parameter int         SETTLE   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       f,
  output logic [1:0] vec_idx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask
);
  state_t     state, state_n;
  logic [1:0] vec_n;
  logic [3:0] mask_n;
  logic       a_n, b_n, busy_n, done_n, pass_n;
  logic       load, expired;

  settle_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (SETTLE_W'(SETTLE)),
    .expired  (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      vec_idx   <= '0;
      fail_mask <= '0;
      a         <= 1'b0;
      b         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      state     <= state_n;
      vec_idx   <= vec_n;
      fail_mask <= mask_n;
      a         <= a_n;
      b         <= b_n;
      busy      <= busy_n;
      done      <= done_n;
      pass      <= pass_n;
    end
  end

  always_comb begin
    state_n = state;
    vec_n   = vec_idx;
    mask_n  = fail_mask;
    a_n     = a;
    b_n     = b;
    busy_n  = busy;
    done_n  = done;
    pass_n  = pass;
    load    = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        // a fresh start from DONE discards the held result
        if (start) begin
          state_n = APPLY;
          vec_n   = '0;
          mask_n  = '0;
          a_n     = 1'b0;
          b_n     = 1'b0;
          busy_n  = 1'b1;
          done_n  = 1'b0;
          pass_n  = 1'b0;
        end
      end
      APPLY: begin
        load    = 1'b1;
        state_n = WAIT;
      end
      WAIT: begin
        if (expired) state_n = SAMPLE;
      end
      SAMPLE: begin
        if (f != EXPECTED[vec_idx]) mask_n[vec_idx] = 1'b1;
        if (vec_idx == 2'(NUM_VECTORS - 1)) begin
          state_n = DONE;
          a_n     = 1'b0;
          b_n     = 1'b0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          pass_n  = (mask_n == '0);
        end else begin
          state_n = APPLY;
          vec_n   = vec_idx + 2'd1;
          a_n     = vec_n[1];
          b_n     = vec_n[0];
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_gate_tt_checker.sv
// Scoreboard bench: two checkers (SETTLE=2 and SETTLE=1) share stimulus.
// A behavioural gate selected by mode drives their f inputs.
module tb_gate_tt_checker;
  typedef struct {
    int         edge_n;
    logic [3:0] mask;
    logic       pass;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] mode = 2'd0;  // 0 OR, 1 AND, 2 stuck-1, 3 stuck-0
  logic [1:0] a_s, b_s, f_s, busy_s, done_s, pass_s;
  logic [1:0] vec_s [2];
  logic [3:0] mask_s [2];

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sbq [2][$];
  int   settle_of [2] = '{2, 1};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    f_s = '0;
    for (int k = 0; k < 2; k++) begin
      case (mode)
        2'd0: f_s[k] = a_s[k] | b_s[k];
        2'd1: f_s[k] = a_s[k] & b_s[k];
        2'd2: f_s[k] = 1'b1;
        default: f_s[k] = 1'b0;
      endcase
    end
  end

  gate_tt_checker #(.EXPECTED(4'b1110), .SETTLE(2)) u0 (
    .clk(clk), .rst(rst), .start(start), .a(a_s[0]), .b(b_s[0]), .f(f_s[0]),
    .vec_idx(vec_s[0]), .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
    .fail_mask(mask_s[0]));

  gate_tt_checker #(.EXPECTED(4'b1110), .SETTLE(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .a(a_s[1]), .b(b_s[1]), .f(f_s[1]),
    .vec_idx(vec_s[1]), .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
    .fail_mask(mask_s[1]));

  task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", nm, k, got, exp, cyc);
    end
  endtask

  task automatic chk_idle(input string nm);
    for (int k = 0; k < 2; k++)
      chk(nm, k, {a_s[k], b_s[k], vec_s[k], busy_s[k], done_s[k], pass_s[k], mask_s[k]}, 32'd0);
  endtask

  // Monitor: a/b follow vec_idx, pass low outside DONE, scoreboard pop on done rise.
  logic [1:0] done_prev = '0, busy_prev = '0;
  logic [7:0] seq [2];
  int         nseq [2] = '{0, 0};
  logic [1:0] last [2];

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        if (busy_s[k]) begin
          chk("a_eq_idx1", k, a_s[k], vec_s[k][1]);
          chk("b_eq_idx0", k, b_s[k], vec_s[k][0]);
          if (!busy_prev[k]) begin
            seq[k] = '0;
            nseq[k] = 0;
          end
          if (!busy_prev[k] || {a_s[k], b_s[k]} != last[k]) begin
            seq[k] = {seq[k][5:0], a_s[k], b_s[k]};
            nseq[k]++;
            last[k] = {a_s[k], b_s[k]};
          end
        end
        if (!done_s[k]) chk("pass_low_not_done", k, pass_s[k], 1'b0);
        if (done_s[k] && !done_prev[k]) begin
          chk("done_ab_zero", k, {a_s[k], b_s[k], busy_s[k]}, 3'b000);
          if (sbq[k].size() == 0) begin
            chk("unexpected_done", k, 1, 0);
          end else begin
            exp_t e;
            e = sbq[k].pop_front();
            chk("done_edge", k, cyc, e.edge_n);
            chk("fail_mask", k, mask_s[k], e.mask);
            chk("pass", k, pass_s[k], e.pass);
            chk("ab_sequence", k, {nseq[k][3:0], seq[k]}, {4'd4, 8'b00_01_10_11});
          end
        end
      end
    end
    done_prev <= done_s;
    busy_prev <= busy_s;
  end

  task automatic wait_both_done();
    int t;
    t = 0;
    while (done_s != 2'b11 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("done_timeout", 0, done_s, 2'b11);
  endtask

  // One sweep on both checkers; hold keeps start high for 8 edges.
  task automatic sweep(input logic [1:0] m, input logic [3:0] emask, input bit hold);
    int se;
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    se    = cyc + 1;
    for (int k = 0; k < 2; k++)
      sbq[k].push_back('{se + 4 * (settle_of[k] + 2), emask, (emask == 4'b0000)});
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("start_clears_done", k, {done_s[k], pass_s[k], mask_s[k]}, 6'd0);
      chk("start_sets_busy", k, {busy_s[k], vec_s[k]}, 3'b100);
    end
    if (hold) repeat (7) @(negedge clk);
    start = 1'b0;
    wait_both_done();
  endtask

  initial begin
    int se;
    repeat (2) @(negedge clk);
    chk_idle("reset_state");
    rst = 1'b0;
    @(negedge clk);
    chk_idle("idle_no_start");

    sweep(2'd0, 4'b0000, 1'b0);  // OR gate
    sweep(2'd1, 4'b0110, 1'b0);  // AND gate
    sweep(2'd2, 4'b0001, 1'b0);  // stuck at 1
    sweep(2'd3, 4'b1110, 1'b0);  // stuck at 0
    sweep(2'd0, 4'b0000, 1'b0);  // OR right after a failing sweep
    sweep(2'd1, 4'b0110, 1'b1);  // start held high during the sweep

    // reset during WAIT of vector 2 on the SETTLE=2 checker
    @(negedge clk);
    mode  = 2'd3;
    start = 1'b1;
    se    = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < se + 9) @(negedge clk);
    chk("mid_vec_idx", 0, {busy_s[0], vec_s[0]}, 3'b110);
    chk("mid_partial_mask", 0, mask_s[0], 4'b0010);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk_idle("reset_mid_sweep");
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk_idle("start_with_rst_dropped");

    sweep(2'd0, 4'b0000, 1'b0);  // clean sweep after reset

    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) chk("scoreboard_empty", k, sbq[k].size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
